// File: rtl/bcd_scan_counter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : bcd_scan_counter_pkg
// Purpose  : Shared BCD constants, direction encoding and one-hot helper
// Revision : 1.0
//============================================================================
package bcd_scan_counter_pkg;

    localparam int           BCD_W   = 4;
    localparam logic [3:0]   BCD_MAX = 4'd9;
    localparam logic [3:0]   BCD_MIN = 4'd0;
    localparam int           ONEHOT_MAX_W = 32;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Callers size-cast the result down to their own digit count.
    function automatic logic [ONEHOT_MAX_W-1:0] idx_to_onehot(input int unsigned idx);
        logic [ONEHOT_MAX_W-1:0] one;
        one = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_counter_if.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : bcd_scan_counter_if
// Purpose  : Control inputs and count/display outputs of bcd_scan_counter
// Revision : 1.0
//============================================================================
interface bcd_scan_counter_if
    import bcd_scan_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                        en;
    logic                        clr;
    logic                        up;
    logic [BCD_W*NUM_DIGITS-1:0] value;
    logic [BCD_W-1:0]            X;
    logic [NUM_DIGITS-1:0]       digit_sel;
    logic                        wrap;

    modport master (
        output en, clr, up,
        input  value, X, digit_sel, wrap
    );

    modport slave (
        input  en, clr, up,
        output value, X, digit_sel, wrap
    );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_counter_digit.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : bcd_digit
// Purpose  : One BCD decade with carry/borrow in and out
// Revision : 1.0
//============================================================================
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             step,
    input  wire logic             up,
    input  wire logic             cin,
    output logic [BCD_W-1:0]      digit,
    output logic                  cout
);
    logic [BCD_W-1:0] r_digit;
    logic             w_active;
    logic             w_at_end;

    assign w_active = step && cin;
    assign w_at_end = (up == DIR_UP) ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN);
    assign cout     = w_active && w_at_end;
    assign digit    = r_digit;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_digit <= BCD_MIN;
        end else if (w_active) begin
            if (w_at_end)
                r_digit <= (up == DIR_UP) ? BCD_MIN : BCD_MAX;
            else if (up == DIR_UP)
                r_digit <= r_digit + 4'd1;
            else
                r_digit <= r_digit - 4'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bcd_scan_counter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : bcd_scan_counter
// Purpose  : Multi-digit BCD up/down counter with time-multiplexed digit scan
// Revision : 1.0
//============================================================================
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int SCAN_DIV   = 1000
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_scan_counter_if.slave  bus
);
    localparam int c_presc_w = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int c_scan_w  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    logic [c_presc_w-1:0]          r_presc;
    logic                          r_wrap;
    logic [c_scan_w-1:0]           r_scan_cnt;
    logic [c_idx_w-1:0]            r_scan_idx;
    logic [NUM_DIGITS-1:0]         r_digit_sel;
    logic                          w_tick;
    logic                          w_step;
    logic [NUM_DIGITS:0]           w_carry;
    logic [BCD_W*NUM_DIGITS-1:0]   w_value;
    logic [c_idx_w-1:0]            w_next_idx;

    assign w_tick     = bus.en && (r_presc == c_presc_last);
    // clr suppresses the step entirely so no carry, and hence no wrap, escapes.
    assign w_step     = w_tick && !bus.clr;
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (bus.clr),
                .step  (w_step),
                .up    (bus.up),
                .cin   (w_carry[i]),
                .digit (w_value[i*BCD_W +: BCD_W]),
                .cout  (w_carry[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_carry[NUM_DIGITS];
            if (bus.clr)
                r_presc <= '0;
            else if (bus.en)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign w_next_idx = (r_scan_idx == c_idx_last) ? '0 : r_scan_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
            r_digit_sel <= NUM_DIGITS'(idx_to_onehot(0));
        end else if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= w_next_idx;
            r_digit_sel <= NUM_DIGITS'(idx_to_onehot(32'(w_next_idx)));
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    assign bus.value     = w_value;
    assign bus.X         = w_value[r_scan_idx*BCD_W +: BCD_W];
    assign bus.digit_sel = r_digit_sel;
    assign bus.wrap      = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_bcd_scan_counter
// Purpose  : Directed self-checking bench for bcd_scan_counter (4 digits)
// Revision : 1.0
//============================================================================
module tb_bcd_scan_counter;
    localparam int ND = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bcd_scan_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_scan_counter #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (1),
        .SCAN_DIV   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          v;
        v = n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick_edge();
        rst_n = 1'b1;
    endtask

    task automatic step_n(input int n);
        bus.en = 1'b1;
        repeat (n) tick_edge();
        bus.en = 1'b0;
    endtask

    // Leaves the bench just after digit_sel has moved onto digit 0.
    task automatic align_scan();
        logic [3:0] prev;
        bit         found;
        prev  = bus.digit_sel;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick_edge();
            if (bus.digit_sel == 4'b0001 && prev != 4'b0001) found = 1'b1;
            prev = bus.digit_sel;
        end
        n_checks++;
        if (!found) $display("FAIL scan_align: digit_sel=%b never entered 0001 within 20 cycles", bus.digit_sel);
        else n_pass++;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.up = 1'b1; bus.clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick_edge();
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL reset_value: got %h want 0000", bus.value); else n_pass++;
        n_checks++; if (bus.X !== 4'd0) $display("FAIL reset_X: got %h want 0", bus.X); else n_pass++;
        n_checks++; if (bus.digit_sel !== 4'b0001) $display("FAIL reset_sel: got %b want 0001", bus.digit_sel); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", bus.wrap); else n_pass++;
        rst_n = 1'b1;
        step_n(57);
        n_checks++; if (bus.value !== 16'h0057) $display("FAIL pre_midreset: got %h want 0057", bus.value); else n_pass++;
        bus.en = 1'b1;
        rst_n  = 1'b0;
        tick_edge();
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL midreset_value: got %h want 0000", bus.value); else n_pass++;
        rst_n  = 1'b1;
        bus.en = 1'b0;
    endtask

    task automatic test_up_carry();
        do_reset();
        bus.up = 1'b1;
        bus.en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick_edge();
            n_checks++;
            if (bus.value !== to_bcd(k)) $display("FAIL up_step%0d: got %h want %h", k, bus.value, to_bcd(k));
            else n_pass++;
        end
        repeat (89) tick_edge();
        n_checks++; if (bus.value !== 16'h0099) $display("FAIL up_to_99: got %h want 0099", bus.value); else n_pass++;
        tick_edge();
        bus.en = 1'b0;
        n_checks++; if (bus.value !== 16'h0100) $display("FAIL up_carry_100: got %h want 0100", bus.value); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL up_carry_wrap: got %b want 0", bus.wrap); else n_pass++;
    endtask

    task automatic test_up_wrap();
        step_n(9899);
        n_checks++; if (bus.value !== 16'h9999) $display("FAIL up_to_9999: got %h want 9999", bus.value); else n_pass++;
        step_n(1);
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL up_wrap_value: got %h want 0000", bus.value); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b1) $display("FAIL up_wrap_pulse: got %b want 1", bus.wrap); else n_pass++;
        tick_edge();
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL up_wrap_width: got %b want 0", bus.wrap); else n_pass++;
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL en_low_hold1: got %h want 0000", bus.value); else n_pass++;
        repeat (3) tick_edge();
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL en_low_hold2: got %h want 0000", bus.value); else n_pass++;
    endtask

    task automatic test_down();
        bus.up = 1'b0;
        step_n(1);
        n_checks++; if (bus.value !== 16'h9999) $display("FAIL down_wrap_value: got %h want 9999", bus.value); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b1) $display("FAIL down_wrap_pulse: got %b want 1", bus.wrap); else n_pass++;
        tick_edge();
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL down_wrap_width: got %b want 0", bus.wrap); else n_pass++;
        do_reset();
        bus.up = 1'b1;
        step_n(100);
        n_checks++; if (bus.value !== 16'h0100) $display("FAIL down_pre_100: got %h want 0100", bus.value); else n_pass++;
        bus.up = 1'b0;
        step_n(1);
        n_checks++; if (bus.value !== 16'h0099) $display("FAIL down_borrow_99: got %h want 0099", bus.value); else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        bus.up = 1'b0;
        step_n(1);
        n_checks++; if (bus.value !== 16'h9999) $display("FAIL clr_pre_9999: got %h want 9999", bus.value); else n_pass++;
        bus.up = 1'b1;
        align_scan();
        bus.clr = 1'b1;
        bus.en  = 1'b1;
        tick_edge();
        bus.clr = 1'b0;
        bus.en  = 1'b0;
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL clr_value: got %h want 0000", bus.value); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL clr_no_wrap: got %b want 0", bus.wrap); else n_pass++;
        n_checks++; if (bus.digit_sel !== 4'b0001) $display("FAIL clr_scan_hold: got %b want 0001", bus.digit_sel); else n_pass++;
        tick_edge();
        n_checks++; if (bus.digit_sel !== 4'b0010) $display("FAIL clr_scan_next: got %b want 0010", bus.digit_sel); else n_pass++;
        n_checks++; if (bus.value !== 16'h0000) $display("FAIL clr_value_hold: got %h want 0000", bus.value); else n_pass++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                     4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        logic [3:0] exp_x   [10] = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd4, 4'd4};
        do_reset();
        bus.up = 1'b1;
        step_n(1234);
        n_checks++; if (bus.value !== 16'h1234) $display("FAIL scan_pre_1234: got %h want 1234", bus.value); else n_pass++;
        align_scan();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick_edge();
            n_checks++;
            if (bus.digit_sel !== exp_sel[i]) $display("FAIL scan_sel%0d: got %b want %b", i, bus.digit_sel, exp_sel[i]);
            else n_pass++;
            n_checks++;
            if (bus.X !== exp_x[i]) $display("FAIL scan_X%0d: got %h want %h", i, bus.X, exp_x[i]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        bus.up  = 1'b1;
        test_reset();
        test_up_carry();
        test_up_wrap();
        test_down();
        test_clear();
        test_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
